// File: rtl/seg_scan_if.sv
// Bus between the multiplexed 7-segment scan pins and the read-back decoder.
// The dp capture port exists only when SEG_DP_CAPTURE_EN is defined.
interface seg_scan_if;
    logic [7:0]  segment;
    logic [7:0]  enable;
    logic [31:0] digits;
    logic        frame_valid;
    logic        frame_done;
    logic        digit_err;
    logic        enable_err;
`ifdef SEG_DP_CAPTURE_EN
    logic [7:0]  dp;

    modport master (output segment, enable,
                    input  digits, frame_valid, frame_done, digit_err, enable_err, dp);
    modport slave  (input  segment, enable,
                    output digits, frame_valid, frame_done, digit_err, enable_err, dp);
`else
    modport master (output segment, enable,
                    input  digits, frame_valid, frame_done, digit_err, enable_err);
    modport slave  (input  segment, enable,
                    output digits, frame_valid, frame_done, digit_err, enable_err);
`endif
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers 8 BCD digits from an active-low multiplexed 7-segment scan bus.
// Optional feature macro: SEG_DP_CAPTURE_EN (adds per-digit decimal-point capture).
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int unsigned STAB_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NDIG   = 8;

    // {enable, segment} through the synchroniser, plus one cycle of history
    logic [15:0]       sync1_q, cur_q, prev_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        seen_q, seen_d;
    logic [31:0]       digits_q, digits_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              digit_err_q, digit_err_d;
    logic              enable_err_q, enable_err_d;
`ifdef SEG_DP_CAPTURE_EN
    logic [7:0]        dp_q, dp_d;
`endif

    logic       cap_c, onehot_c, multi_c, tmo_hit_c;
    logic [7:0] en_low_c;
    logic [3:0] dec_c;

    function automatic logic [3:0] seg_decode(input logic [6:0] pat);
        logic [3:0] d;
        case (pat)
            7'b0000001: d = 4'h0;
            7'b1001111: d = 4'h1;
            7'b0010010: d = 4'h2;
            7'b0000110: d = 4'h3;
            7'b1001100: d = 4'h4;
            7'b0100100: d = 4'h5;
            7'b0100000: d = 4'h6;
            7'b0001111: d = 4'h7;
            7'b0000000: d = 4'h8;
            7'b0000100: d = 4'h9;
            7'b1111111: d = 4'hF;
            default:    d = 4'hE;
        endcase
        return d;
    endfunction

    assign en_low_c  = ~cur_q[15:8];
    assign onehot_c  = $onehot(en_low_c);
    assign multi_c   = (en_low_c != 8'h00) && !onehot_c;
    assign dec_c     = seg_decode(cur_q[7:1]);
    assign cap_c     = (cur_q == prev_q) && (stab_q == STAB_W'(SETTLE_CYCLES - 1));
    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Stability counting, capture, frame tracking and timeout
    always_comb begin
        stab_d        = stab_q;
        tmo_d         = tmo_q;
        seen_d        = seen_q;
        digits_d      = digits_q;
        frame_valid_d = frame_valid_q;
        frame_done_d  = 1'b0;
        digit_err_d   = 1'b0;
        enable_err_d  = 1'b0;
`ifdef SEG_DP_CAPTURE_EN
        dp_d          = dp_q;
`endif

        if (cur_q != prev_q) begin
            stab_d = '0;
        end else if (stab_q < STAB_W'(SETTLE_CYCLES)) begin
            stab_d = stab_q + STAB_W'(1);
        end

        if (tmo_q < TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (tmo_hit_c) begin
            seen_d = '0;
        end

        // A successful capture overrides the timeout's counter and seen-mask effects
        if (cap_c && onehot_c) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (en_low_c[i]) begin
                    digits_d[4*i +: 4] = dec_c;
`ifdef SEG_DP_CAPTURE_EN
                    dp_d[i] = ~cur_q[0];
`endif
                end
            end
            digit_err_d = (dec_c == 4'hE);
            tmo_d       = '0;
            if ((seen_q | en_low_c) == 8'hFF) begin
                seen_d        = '0;
                frame_done_d  = 1'b1;
                frame_valid_d = 1'b1;
            end else begin
                seen_d = seen_q | en_low_c;
            end
        end else if (cap_c && multi_c) begin
            enable_err_d = 1'b1;
        end

        if (tmo_hit_c) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 16'hFFFF;
            cur_q         <= 16'hFFFF;
            prev_q        <= 16'hFFFF;
            stab_q        <= '0;
            tmo_q         <= '0;
            seen_q        <= '0;
            digits_q      <= 32'hFFFF_FFFF;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            digit_err_q   <= 1'b0;
            enable_err_q  <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
            dp_q          <= 8'h00;
`endif
        end else begin
            sync1_q       <= {bus.enable, bus.segment};
            cur_q         <= sync1_q;
            prev_q        <= cur_q;
            stab_q        <= stab_d;
            tmo_q         <= tmo_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            frame_done_q  <= frame_done_d;
            digit_err_q   <= digit_err_d;
            enable_err_q  <= enable_err_d;
`ifdef SEG_DP_CAPTURE_EN
            dp_q          <= dp_d;
`endif
        end
    end

    assign bus.digits      = digits_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.digit_err   = digit_err_q;
    assign bus.enable_err  = enable_err_q;
`ifdef SEG_DP_CAPTURE_EN
    assign bus.dp          = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: vector table, corner sequences and a
// randomized scan checked against a slot-level reference model.
module tb_seg_scan_decoder;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 100;

    logic clk = 1'b0;
    logic rst;

    seg_scan_if bus ();

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  en;
        logic [7:0]  seg;
        logic [31:0] dig;
        logic        fv;
        logic [2:0]  pulses;   // {frame_done, digit_err, enable_err}
    } vec_t;

    vec_t       tbl [14];
    logic [6:0] pat [11];

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0, de_cnt = 0, ee_cnt = 0;

    // reference model state
    logic [31:0] m_dig;
    logic [7:0]  m_seen;
    logic        m_fv;
    int unsigned m_since;
    int          m_fd, m_de, m_ee;

    always @(negedge clk) begin
        if (bus.frame_done) fd_cnt++;
        if (bus.digit_err)  de_cnt++;
        if (bus.enable_err) ee_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic slot(input logic [7:0] en, input logic [7:0] seg, input int h);
        bus.enable  = en;
        bus.segment = seg;
        cycles(h);
    endtask

    task automatic reset_dut();
        bus.enable  = 8'hFF;
        bus.segment = 8'hFF;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 11; k++) begin
            if (pat[k] == p) return (k == 10) ? 4'hF : 4'(k);
        end
        return 4'hE;
    endfunction

    task automatic m_adv(input int n);
        for (int k = 0; k < n; k++) begin
            if (m_since == TMO - 1) begin
                m_fv   = 1'b0;
                m_seen = 8'h00;
            end
            if (m_since < TMO) m_since++;
        end
    endtask

    // One capture edge of a stable window holding {en, seg}
    task automatic m_cap(input logic [7:0] en, input logic [7:0] seg);
        logic hit;
        hit = (m_since == TMO - 1);
        if (m_since < TMO) m_since++;
        if ($countones(~en) == 1) begin
            for (int k = 0; k < 8; k++) begin
                if (!en[k]) begin
                    m_dig[k*4 +: 4] = ref_decode(seg[7:1]);
                    m_seen[k] = 1'b1;
                end
            end
            if (ref_decode(seg[7:1]) == 4'hE) m_de++;
            m_since = 0;
            if (m_seen == 8'hFF) begin
                m_seen = 8'h00;
                m_fd++;
                m_fv = 1'b1;
            end
            if (hit) m_fv = 1'b0;
        end else begin
            if ($countones(~en) >= 2) m_ee++;
            if (hit) begin
                m_fv   = 1'b0;
                m_seen = 8'h00;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, d0, e0, lat, n;
        bit found;
        logic [7:0] en, seg;
        logic [15:0] prevv;
        bit long_slot;
        int h;

        pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111111};
        tbl[0]  = '{8'hFE, 8'h9F, 32'hFFFF_FFF1, 1'b0, 3'b000};
        tbl[1]  = '{8'hFD, 8'h25, 32'hFFFF_FF21, 1'b0, 3'b000};
        tbl[2]  = '{8'hFB, 8'h0D, 32'hFFFF_F321, 1'b0, 3'b000};
        tbl[3]  = '{8'hF7, 8'h99, 32'hFFFF_4321, 1'b0, 3'b000};
        tbl[4]  = '{8'hEF, 8'h49, 32'hFFF5_4321, 1'b0, 3'b000};
        tbl[5]  = '{8'hDF, 8'h41, 32'hFF65_4321, 1'b0, 3'b000};
        tbl[6]  = '{8'hBF, 8'h1F, 32'hF765_4321, 1'b0, 3'b000};
        tbl[7]  = '{8'h7F, 8'h01, 32'h8765_4321, 1'b1, 3'b100};
        tbl[8]  = '{8'hFE, 8'h55, 32'h8765_432E, 1'b1, 3'b010};
        tbl[9]  = '{8'hFC, 8'h03, 32'h8765_432E, 1'b1, 3'b001};
        tbl[10] = '{8'hFF, 8'h25, 32'h8765_432E, 1'b1, 3'b000};
        tbl[11] = '{8'hFE, 8'h03, 32'h8765_4320, 1'b1, 3'b000};
        tbl[12] = '{8'hFE, 8'h09, 32'h8765_4329, 1'b1, 3'b000};
        tbl[13] = '{8'hFD, 8'hFF, 32'h8765_43F9, 1'b1, 3'b000};

        // reset with arbitrary pin values
        rst = 1'b1;
        bus.segment = 8'($urandom);
        bus.enable  = 8'($urandom);
        cycles(3);
        check("rst_digits", bus.digits, 32'hFFFF_FFFF);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_pulses", {29'd0, bus.frame_done, bus.digit_err, bus.enable_err}, 32'd0);
        bus.segment = 8'hFF;
        bus.enable  = 8'hFF;
        cycles(1);
        rst = 1'b0;
        fd_cnt = 0; de_cnt = 0; ee_cnt = 0;
        cycles(20);
        check("idle_digits", bus.digits, 32'hFFFF_FFFF);
        check("idle_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("idle_pulses", 32'(fd_cnt + de_cnt + ee_cnt), 32'd0);

        // too-short window must not capture
        slot(8'hFE, 8'h03, 3);
        slot(8'hFF, 8'hFF, 12);
        check("short_window_digit0", 32'(bus.digits[3:0]), 32'hF);
        check("short_window_pulses", 32'(fd_cnt + de_cnt + ee_cnt), 32'd0);

        // input edge to digits update latency
        bus.enable  = 8'hFE;
        bus.segment = 8'h49;
        lat = 99;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.digits[3:0] == 4'h5) begin
                lat = k;
                break;
            end
        end
        check("capture_latency", 32'(lat), 32'(2 + 1 + SETTLE));
        @(negedge clk);
        #1;

        // vector table
        for (int i = 0; i < 14; i++) begin
            f0 = fd_cnt; d0 = de_cnt; e0 = ee_cnt;
            slot(tbl[i].en, tbl[i].seg, 10);
            check($sformatf("vec%0d_digits", i), bus.digits, tbl[i].dig);
            check($sformatf("vec%0d_frame_valid", i), 32'(bus.frame_valid), 32'(tbl[i].fv));
            check($sformatf("vec%0d_pulse_counts", i),
                  {8'(fd_cnt - f0), 8'(de_cnt - d0), 8'(ee_cnt - e0), 8'h00},
                  {8'(tbl[i].pulses[2]), 8'(tbl[i].pulses[1]), 8'(tbl[i].pulses[0]), 8'h00});
        end

        // frame_valid timeout measured from the frame-completing capture
        reset_dut();
        for (int i = 0; i < 7; i++) slot(tbl[i].en, tbl[i].seg, 10);
        bus.enable  = tbl[7].en;
        bus.segment = tbl[7].seg;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_done) begin
                found = 1'b1;
                break;
            end
        end
        check("tmo_frame_done_seen", 32'(found), 32'd1);
        check("tmo_frame_valid_set", 32'(bus.frame_valid), 32'd1);
        bus.enable = 8'hFF;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.frame_valid) break;
        end
        check("tmo_fall_cycles", 32'(n), 32'(TMO));
        check("tmo_digits_held", bus.digits, 32'h8765_4321);
        @(negedge clk);
        #1;

        // reset mid-frame discards the partial seen mask
        for (int i = 0; i < 4; i++) slot(tbl[i].en, tbl[i].seg, 10);
        reset_dut();
        check("midrst_digits", bus.digits, 32'hFFFF_FFFF);
        f0 = fd_cnt;
        for (int i = 4; i < 8; i++) slot(tbl[i].en, tbl[i].seg, 10);
        check("midrst_no_frame", 32'(fd_cnt - f0), 32'd0);
        check("midrst_frame_valid", 32'(bus.frame_valid), 32'd0);
        for (int i = 0; i < 4; i++) slot(tbl[i].en, tbl[i].seg, 10);
        check("midrst_frame_after", 32'(fd_cnt - f0), 32'd1);
        check("midrst_frame_valid_after", 32'(bus.frame_valid), 32'd1);

`ifdef SEG_DP_CAPTURE_EN
        slot(8'hF7, 8'b10011110, 10);
        check("dp_digit3", 32'(bus.digits[15:12]), 32'h1);
        check("dp_bit3", 32'(bus.dp[3]), 32'd1);
        slot(8'hFB, 8'h0D, 10);
        check("dp_bit2_off", 32'(bus.dp[2]), 32'd0);
        check("dp_digit2", 32'(bus.digits[11:8]), 32'h3);
`endif

        // randomized scan against the slot-level model
        reset_dut();
        fd_cnt = 0; de_cnt = 0; ee_cnt = 0;
        m_dig = 32'hFFFF_FFFF; m_seen = 8'h00; m_fv = 1'b0; m_since = 0;
        m_fd = 0; m_de = 0; m_ee = 0;
        prevv = 16'hFFFF;
        for (int s = 0; s < 150; s++) begin
            do begin
                h = int'($urandom_range(0, 9));
                if (h < 7)       en = ~8'(1 << $urandom_range(0, 7));
                else if (h == 7) en = 8'hFF;
                else             en = 8'($urandom);
                if ($urandom_range(0, 4) == 0) seg = 8'($urandom);
                else seg = {pat[$urandom_range(0, 10)], 1'($urandom)};
            end while ({en, seg} == prevv);
            prevv = {en, seg};
            long_slot = ($urandom_range(0, 3) != 0);
            h = long_slot ? int'($urandom_range(8, 12)) : int'($urandom_range(1, 3));
            slot(en, seg, h);
            if (long_slot) begin
                m_adv(2 + 1 + SETTLE - 1);
                m_cap(en, seg);
                m_adv(h - (2 + 1 + SETTLE));
                check($sformatf("rnd%0d_digits", s), bus.digits, m_dig);
                check($sformatf("rnd%0d_frame_valid", s), 32'(bus.frame_valid), 32'(m_fv));
                check($sformatf("rnd%0d_pulse_counts", s),
                      {8'(fd_cnt), 8'(de_cnt), 8'(ee_cnt), 8'h00},
                      {8'(m_fd), 8'(m_de), 8'(m_ee), 8'h00});
            end else begin
                m_adv(h);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
